// File: rtl/div_unit_ctrl.sv
// div_unit_ctrl
//   Sequences one integer divide/remainder request at a time through an
//   external iterative divider. Operands of *W ops are normalised to 64 bits
//   on acceptance. Divide-by-zero and signed overflow are resolved locally
//   without starting the divider. Flush aborts any operation.
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   flush                   : abort current operation (highest priority)
//   in_*                    : request from EXU (valid/ready handshake)
//   out_*                   : result to consumer (valid/ready handshake)
//   dv_*                    : iterative divider start/abort/operands/results
module div_unit_ctrl #(
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_rem,
   input  logic             in_signed,
   input  logic             in_word,
   input  logic [63:0]      in_src1,
   input  logic [63:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             dv_valid,
   output logic             dv_flush,
   output logic             dv_divw,
   output logic [1:0]       dv_signed,
   output logic [63:0]      dv_dividend,
   output logic [63:0]      dv_divisor,
   input  logic             dv_ready,
   input  logic             dv_outvalid,
   input  logic [63:0]      dv_quotient,
   input  logic [63:0]      dv_remainder
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       r_state;
   logic             r_rem;
   logic             r_signed;
   logic             r_word;
   logic [TAG_W-1:0] r_tag;
   logic [63:0]      r_src1;
   logic [63:0]      r_src2;
   logic [63:0]      r_result;

   logic        w_accept;
   logic [63:0] w_n1;
   logic [63:0] w_n2;
   logic        w_dz;
   logic        w_ovf;
   logic [63:0] w_spec_res;

   // *W results are always sign-extended from bit 31, even for unsigned ops
   function automatic logic [63:0] f_fmt(input logic [63:0] x, input logic w);
      return w ? {{32{x[31]}}, x[31:0]} : x;
   endfunction

   assign in_ready  = (r_state == S_IDLE) && !flush;
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == S_DONE);
   assign out_data  = r_result;
   assign out_tag   = r_tag;

   assign dv_valid    = (r_state == S_ISSUE) && dv_ready && !flush;
   assign dv_flush    = flush && (r_state == S_WAIT);
   assign dv_divw     = r_word;
   assign dv_signed   = {2{r_signed}};
   assign dv_dividend = r_src1;
   assign dv_divisor  = r_src2;

   always_comb begin
      w_n1 = in_src1;
      w_n2 = in_src2;
      if (in_word) begin
         w_n1 = in_signed ? {{32{in_src1[31]}}, in_src1[31:0]} : {32'd0, in_src1[31:0]};
         w_n2 = in_signed ? {{32{in_src2[31]}}, in_src2[31:0]} : {32'd0, in_src2[31:0]};
      end
   end

   assign w_dz  = (w_n2 == 64'd0);
   // most-negative dividend over -1; the *W form is the sign-extended 32-bit one
   assign w_ovf = in_signed && (w_n2 == {64{1'b1}}) &&
                  (w_n1 == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

   always_comb begin
      w_spec_res = 64'd0;
      if (w_dz)
         w_spec_res = in_rem ? w_n1 : {64{1'b1}};
      else if (w_ovf)
         w_spec_res = in_rem ? 64'd0 : w_n1;
      w_spec_res = f_fmt(w_spec_res, in_word);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_rem    <= 1'b0;
         r_signed <= 1'b0;
         r_word   <= 1'b0;
         r_tag    <= '0;
         r_src1   <= 64'd0;
         r_src2   <= 64'd0;
         r_result <= 64'd0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem    <= in_rem;
                  r_signed <= in_signed;
                  r_word   <= in_word;
                  r_tag    <= in_tag;
                  r_src1   <= w_n1;
                  r_src2   <= w_n2;
                  if (w_dz || w_ovf) begin
                     r_result <= w_spec_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: if (dv_ready) r_state <= S_WAIT;
            S_WAIT: begin
               if (dv_outvalid) begin
                  r_result <= f_fmt(r_rem ? dv_remainder : dv_quotient, r_word);
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  if (out_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit_ctrl.sv
// Self-checking bench for div_unit_ctrl: directed cases plus random ops,
// checked against an arithmetic reference of the divide/remainder rules.
module tb_div_unit_ctrl;

   localparam int TAG_W = 5;

   logic             clock = 1'b0;
   logic             reset, flush, in_valid, in_ready, in_rem, in_signed, in_word;
   logic [63:0]      in_src1, in_src2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid, out_ready;
   logic [63:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             dv_valid, dv_flush, dv_divw;
   logic [1:0]       dv_signed;
   logic [63:0]      dv_dividend, dv_divisor;
   logic             dv_ready, dv_outvalid;
   logic [63:0]      dv_quotient, dv_remainder;

   int n_vec = 0;
   int n_err = 0;

   // divider environment state
   int          div_lat = 4;
   int          n_issue = 0;
   logic [63:0] last_a, last_b;
   logic        last_w;
   logic [1:0]  last_s;

   always #5 clock = ~clock;

   div_unit_ctrl #(.TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_rem(in_rem),
      .in_signed(in_signed), .in_word(in_word), .in_src1(in_src1),
      .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag),
      .dv_valid(dv_valid), .dv_flush(dv_flush), .dv_divw(dv_divw),
      .dv_signed(dv_signed), .dv_dividend(dv_dividend), .dv_divisor(dv_divisor),
      .dv_ready(dv_ready), .dv_outvalid(dv_outvalid),
      .dv_quotient(dv_quotient), .dv_remainder(dv_remainder)
   );

   // Iterative divider stand-in: ignores dv_flush and reset on purpose so
   // stale completions reach the controller.
   initial begin
      dv_ready = 1'b1; dv_outvalid = 1'b0;
      dv_quotient = 64'd0; dv_remainder = 64'd0;
   end

   always begin : divider
      logic        issue, busy;
      int          cnt;
      logic [63:0] q, r, pq, pr;
      logic signed [63:0] sa, sb;
      busy = 1'b0; cnt = 0; pq = 0; pr = 0; q = 0; r = 0;
      forever begin
         @(negedge clock);
         issue = dv_valid;
         if (issue) begin
            last_a = dv_dividend; last_b = dv_divisor;
            last_w = dv_divw;     last_s = dv_signed;
            if (dv_divisor == 64'd0) begin
               q = {64{1'b1}}; r = dv_dividend;
            end else if (dv_signed[0]) begin
               sa = dv_dividend; sb = dv_divisor;
               q = sa / sb; r = sa % sb;
            end else begin
               q = dv_dividend / dv_divisor; r = dv_dividend % dv_divisor;
            end
         end
         @(posedge clock); #1;
         dv_outvalid  = 1'b0;
         dv_quotient  = {$urandom, $urandom};
         dv_remainder = {$urandom, $urandom};
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               dv_outvalid = 1'b1; dv_quotient = pq; dv_remainder = pr;
               busy = 1'b0; dv_ready = 1'b1;
            end
         end
         if (issue) begin
            busy = 1'b1; dv_ready = 1'b0; cnt = div_lat;
            pq = q; pr = r; n_issue++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_special(input logic sgn, word, input logic [63:0] a, b);
      if (word)
         return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}});
   endfunction

   // Reference result from the instruction semantics
   function automatic logic [63:0] ref_div(input logic rem, sgn, word, input logic [63:0] a, b);
      logic [31:0] a32, b32, q32, r32;
      logic signed [31:0] sa32, sb32;
      logic [63:0] q, r;
      logic signed [63:0] sa, sb;
      if (word) begin
         a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
         if (b32 == 0) begin q32 = '1; r32 = a32; end
         else if (sgn && a32 == 32'h8000_0000 && b32 == '1) begin q32 = a32; r32 = 0; end
         else if (sgn) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
         else begin q32 = a32 / b32; r32 = a32 % b32; end
         return rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      end
      sa = a; sb = b;
      if (b == 0) begin q = '1; r = a; end
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
      else if (sgn) begin q = sa / sb; r = sa % sb; end
      else begin q = a / b; r = a % b; end
      return rem ? r : q;
   endfunction

   task automatic send_req(input logic rem, sgn, word, input logic [63:0] a, b,
                           input logic [TAG_W-1:0] tag, input string nm);
      logic ok;
      @(posedge clock); #1;
      in_valid = 1; in_rem = rem; in_signed = sgn; in_word = word;
      in_src1 = a; in_src2 = b; in_tag = tag;
      ok = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk({nm, "_accept_timeout"}, in_ready, 1);
      @(posedge clock); #1;
      in_valid = 0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
   endtask

   task automatic run_op(input logic rem, sgn, word, input logic [63:0] a, b,
                         input logic [TAG_W-1:0] tag, input int hold, input string nm);
      logic [63:0] exp;
      logic        spec, ok, prev_ov;
      int          base, cyc;
      exp  = ref_div(rem, sgn, word, a, b);
      spec = is_special(sgn, word, a, b);
      base = n_issue;
      send_req(rem, sgn, word, a, b, tag, nm);
      ok = 0; prev_ov = 0; cyc = 0;
      for (int c = 0; c < 300; c++) begin
         if (c != 0) @(negedge clock);
         else @(negedge clock);
         if (out_valid) begin ok = 1; cyc = c; break; end
         prev_ov = dv_outvalid;
      end
      if (!ok) begin
         chk({nm, "_out_timeout"}, out_valid, 1);
         return;
      end
      if (spec) chk({nm, "_spec_latency"}, cyc, 0);
      else      chk({nm, "_after_dv_outvalid"}, prev_ov, 1);
      chk({nm, "_data"}, out_data, exp);
      chk({nm, "_tag"}, out_tag, tag);
      chk({nm, "_dv_pulses"}, n_issue - base, spec ? 0 : 1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         chk({nm, "_hold_valid"}, out_valid, 1);
         chk({nm, "_hold_data"}, out_data, exp);
         chk({nm, "_hold_tag"}, out_tag, tag);
         chk({nm, "_hold_in_ready"}, in_ready, 0);
      end
      @(posedge clock); #1; out_ready = 1;
      @(posedge clock); #1; out_ready = 0;
      @(negedge clock);
      chk({nm, "_in_ready_after"}, in_ready, 1);
   endtask

   initial begin : stim
      int seen;
      logic [63:0] a, b;
      int kind;
      reset = 1; flush = 0; in_valid = 0; in_rem = 0; in_signed = 0; in_word = 0;
      in_src1 = 0; in_src2 = 0; in_tag = 0; out_ready = 0;
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_dv_valid", dv_valid, 0);
      chk("rst_dv_flush", dv_flush, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dv_dividend", dv_dividend, 0);

      // signed DIV -7 / 2
      run_op(0, 1, 0, -64'sd7, 64'sd2, 5'd3, 0, "div_neg");
      chk("div_neg_out", out_data, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("div_neg_dv_signed", last_s, 2'b11);

      // REMUW with junk upper bits
      run_op(1, 0, 1, 64'h1_0000_0007, 64'h1_0000_0002, 5'd9, 0, "remuw");
      chk("remuw_dividend", last_a, 64'd7);
      chk("remuw_divisor", last_b, 64'd2);
      chk("remuw_divw", last_w, 1);
      chk("remuw_out", out_data, 64'd1);

      // divide-by-zero and overflow
      run_op(0, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd1, 0, "divu_z");
      run_op(1, 1, 0, 64'hFEDC_BA98_7654_3210, 64'd0, 5'd2, 0, "rem_z");
      run_op(0, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd4, 0, "divw_ovf");
      chk("divw_ovf_out", out_data, 64'hFFFF_FFFF_8000_0000);
      run_op(1, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 0, "remw_ovf");
      run_op(0, 1, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd6, 0, "div_ovf");
      run_op(0, 0, 1, 64'hFFFF_FFFF, 64'd1, 5'd7, 0, "divuw_sext");

      // back-pressure in DONE
      div_lat = 6;
      run_op(0, 1, 0, 64'd100, 64'd7, 5'd17, 5, "hold");

      // flush deep into WAIT, stale completion must be dropped
      div_lat = 30;
      seen = n_issue;
      send_req(0, 0, 0, 64'd1000, 64'd3, 5'd11, "flush");
      for (int c = 0; c < 50 && n_issue == seen; c++) @(posedge clock);
      chk("flush_issued", n_issue - seen, 1);
      repeat (9) @(posedge clock);
      #1 flush = 1;
      @(negedge clock);
      chk("flush_dv_flush", dv_flush, 1);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clock); #1 flush = 0;
      @(negedge clock);
      chk("flush_idle", in_ready, 1);
      seen = 0;
      for (int c = 0; c < 35; c++) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      chk("flush_no_out", seen, 0);

      // reset mid-operation
      div_lat = 20;
      seen = n_issue;
      send_req(1, 0, 0, 64'd77, 64'd5, 5'd21, "rst_mid");
      for (int c = 0; c < 50 && n_issue == seen; c++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1 reset = 1;
      @(posedge clock); #1 reset = 0;
      @(negedge clock);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_tag", out_tag, 0);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      chk("rst_mid_no_out", seen, 0);

      // random ops
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (kind == 0) b = 64'd0;
         else if (kind == 1) begin
            a = 64'h8000_0000_0000_0000 | ({$urandom, $urandom} & 64'hFFFF_FFFF_0000_0000);
            a[31:0] = 32'h8000_0000;
            b = {64{1'b1}};
         end else if (kind < 5) b = {$urandom, $urandom} >> $urandom_range(40, 62);
         div_lat = $urandom_range(1, 8);
         run_op($urandom_range(0, 1), (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), a, b, 5'($urandom), $urandom_range(0, 2), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
